// File: rtl/gf_exp_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gf_exp_lookup_arbiter
//  Description : Round-robin arbiter sharing one GF(2^8) antilog (GFINDEX)
//                table between NUM_REQ requesters. Two-stage pipeline with
//                valid/ready handshakes on both sides. Each response carries
//                the requester ID of the lookup that produced it.
//                Field polynomial x^8+x^6+x^4+x^3+x^2+x+1 (0x15F).
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_exp_lookup_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_idx,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data
);

  // Low byte of the field polynomial: x^8 reduces to this value.
  localparam logic [7:0] C_POLY_LO = 8'h5F;

  // GF(2^8) multiply, MSB-first shift-and-add with reduction each step.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? C_POLY_LO : 8'h00);
      if (b[i]) begin
        p = p ^ a;
      end
    end
    return p;
  endfunction

  // Pipeline state
  logic            r_s1_valid;
  logic [ID_W-1:0] r_s1_id;
  logic [7:0]      r_s1_idx;
  logic            r_s2_valid;
  logic [ID_W-1:0] r_s2_id;
  logic [7:0]      r_s2_data;
  logic [ID_W-1:0] r_ptr;
  // Goes high on the first edge after reset release so no request is
  // granted while reset is (or has just been) asserted.
  logic            r_run;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_found;
  logic                w_take;
  logic [ID_W-1:0]     w_gnt_id;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [7:0]          w_sel_idx;
  logic [7:0]          w_cap_idx;
  logic [7:0]          w_exp;

  // Stall chain: a stage may move when it is empty or its successor moves.
  assign w_s2_adv = !r_s2_valid || rsp_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    w_found  = 1'b0;
    w_gnt_id = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      if (!w_found && req_valid[sum[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = sum[ID_W-1:0];
      end
    end
  end

  assign w_take = w_found && w_s1_adv && r_run;

  // One-hot grant, presented directly as req_ready.
  always_comb begin
    w_gnt = '0;
    if (w_take) begin
      w_gnt[w_gnt_id] = 1'b1;
    end
  end

  assign req_ready = w_gnt;

  // Select the granted requester's exponent.
  always_comb begin
    w_sel_idx = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_id == ID_W'(k)) begin
        w_sel_idx = req_idx[8*k +: 8];
      end
    end
  end

  // alpha^255 == alpha^0, so fold 255 onto 0 before it enters the table.
  assign w_cap_idx = (w_sel_idx == 8'hFF) ? 8'h00 : w_sel_idx;

  // GFINDEX: alpha^n as the product of alpha^(2^k) over the set bits of n.
  // The squares chain is constant and collapses to fixed multipliers.
  logic [7:0] w_sq  [0:7];
  logic [7:0] w_acc [0:8];

  assign w_sq[0]  = 8'h02;
  assign w_acc[0] = 8'h01;

  for (genvar k = 0; k < 8; k++) begin : g_pow
    if (k < 7) begin : g_sq
      assign w_sq[k+1] = gf_mul(w_sq[k], w_sq[k]);
    end
    assign w_acc[k+1] = r_s1_idx[k] ? gf_mul(w_acc[k], w_sq[k]) : w_acc[k];
  end

  assign w_exp = w_acc[8];

  // Reset-release qualifier for the grant path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Round-robin pointer moves just past the last granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + ID_W'(1);
    end
  end

  // Stage 1: capture the granted request (ID and folded exponent).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_idx   <= 8'h00;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_id  <= w_gnt_id;
        r_s1_idx <= w_cap_idx;
      end
    end
  end

  // Stage 2: capture the table output; payload only changes on real data
  // so the response bus stays quiet while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_data  <= 8'h00;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_id   <= r_s1_id;
        r_s2_data <= w_exp;
      end
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = r_s2_data;

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_rsp_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_data)));
  a_no_255 : assert property (@(posedge clk) disable iff (!rst_n)
    r_s1_idx != 8'hFF);
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf_exp_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf_exp_lookup_arbiter
//  Description : Scoreboard bench for gf_exp_lookup_arbiter. A driver feeds
//                per-requester queues, a monitor records accepted requests
//                into an expected-response queue and checks every response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_exp_lookup_arbiter;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_idx = '0;
  logic [NREQ-1:0] req_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_data;

  gf_exp_lookup_arbiter #(.NUM_REQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  // Per-requester pending exponents
  logic [7:0] pbuf [NREQ][512];
  int         phead [NREQ];
  int         ptail [NREQ];
  bit [NREQ-1:0] hs = '0;
  int         ctl = 1;          // 0: rsp_ready low, 1: high, 2: random
  int         cyc = 0;
  logic [9:0] sb[$];
  int         log_id[$];
  int         log_cyc[$];
  int         n_rsp = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         prev_stall = 0;
  logic [1:0] prev_id;
  logic [7:0] prev_data;

  // Reference: repeated multiply by alpha with reduction by 0x15F.
  function automatic logic [7:0] alpha_pow(input int n);
    int m;
    logic [7:0] v;
    m = n % 255;
    v = 8'h01;
    for (int k = 0; k < m; k++) begin
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h5F : 8'h00);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic [7:0] n);
    pbuf[id][ptail[id]] = n;
    ptail[id]++;
  endtask

  function automatic bit all_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (phead[i] != ptail[i]) e = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (all_empty() && sb.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_drain: timed out after %0d cycles, pending=%0d", name, budget, sb.size());
    end
  endtask

  // Single isolated lookup with hand-computed result and latency check.
  task automatic single(input int id, input logic [7:0] n, input logic [7:0] exp, input string name);
    int acc;
    bit done;
    acc = -1;
    done = 1'b0;
    push(id, n);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (acc < 0 && req_valid[id] && req_ready[id]) acc = k;
      if (rsp_valid) begin
        done = 1'b1;
        chk({name, "_id"}, 32'(rsp_id), 32'(id));
        chk({name, "_data"}, 32'(rsp_data), 32'(exp));
        chk({name, "_latency"}, 32'(k - acc), 32'd2);
        break;
      end
    end
    if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    wait_drain(20, name);
  endtask

  // Driver: present each requester's head entry until it is accepted.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) phead[i]++;
        if (phead[i] < ptail[i]) begin
          req_valid[i] = 1'b1;
          req_idx[8*i +: 8] = pbuf[i][phead[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      case (ctl)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard push on request handshake, pop/compare on response.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        hs = '0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_id", 32'(rsp_id), 32'(prev_id));
          chk("hold_data", 32'(rsp_data), 32'(prev_data));
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          log_id.push_back(int'(rsp_id));
          log_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_data), 32'h100);
          end else begin
            logic [9:0] e;
            e = sb.pop_front();
            chk("sb_id", 32'(rsp_id), 32'(e[9:8]));
            chk("sb_data", 32'(rsp_data), 32'(e[7:0]));
          end
        end
        chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
          hs[i] = req_valid[i] & req_ready[i];
          if (hs[i]) sb.push_back({2'(i), alpha_pow(int'(pbuf[i][phead[i]]))});
        end
        prev_stall = rsp_valid & !rsp_ready;
        prev_id = rsp_id;
        prev_data = rsp_data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r0;
    bit seen;
    for (int i = 0; i < NREQ; i++) begin
      phead[i] = 0;
      ptail[i] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single lookups with hand-computed field values
    single(0, 8'd8,   8'h5F, "idx8_req0");
    single(2, 8'd255, 8'h01, "idx255_req2");
    single(1, 8'd254, 8'hAF, "idx254_req1");
    single(3, 8'd7,   8'h80, "idx7_req3");
    single(0, 8'd12,  8'h8C, "idx12_req0");
    single(1, 8'd1,   8'h02, "idx1_req1");
    single(2, 8'd0,   8'h01, "idx0_req2");

    // Reset with both stages full
    for (int i = 0; i < NREQ; i++) begin
      push(i, 8'(10 + i));
      push(i, 8'(20 + i));
    end
    ctl = 0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) phead[i] = ptail[i];
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    ctl = 1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    push(3, 8'd50);
    push(0, 8'd60);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (req_ready != '0) begin
        chk("postrst_first_grant", 32'(req_ready), 32'h1);
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("postrst_grant_timeout", 32'd0, 32'd1);
    wait_drain(20, "postrst");

    // Full load with a 3-cycle backpressure window
    base = log_id.size();
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < 6; j++) push(i, 8'(40 * i + j));
    end
    repeat (6) @(negedge clk);
    #1;
    ctl = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    ctl = 1;
    wait_drain(60, "fullload");
    chk("fullload_count", 32'(log_id.size() - base), 32'd24);
    if (log_id.size() - base == 24) begin
      for (int k = 0; k < 24; k++) chk("rr_order", 32'(log_id[base + k]), 32'(k % 4));
      for (int k = 0; k < 3; k++) chk("rr_back_to_back", 32'(log_cyc[base + k + 1] - log_cyc[base + k]), 32'd1);
    end

    // Sweep of all exponents, random requesters and random rsp_ready
    r0 = n_rsp;
    ctl = 2;
    for (int n = 0; n < 256; n++) push(int'($urandom_range(0, NREQ - 1)), 8'(n));
    wait_drain(4000, "sweep");
    ctl = 1;
    chk("sweep_count", 32'(n_rsp - r0), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
